// File: rtl/program_counter_if.sv
// ============================================================================
// Module      : program_counter_if
// Description : Request/result bundle between control unit, ALU compare and
//               the fetch-stage program counter.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface program_counter_if;
    logic        load;
    logic        inc;
    logic        ALU_out;
    logic        Disable;
    logic [31:0] data;
    logic [31:0] immediate_value;
    logic [31:0] pc_val;

    modport master (
        output load,
        output inc,
        output ALU_out,
        output Disable,
        output data,
        output immediate_value,
        input  pc_val
    );

    modport slave (
        input  load,
        input  inc,
        input  ALU_out,
        input  Disable,
        input  data,
        input  immediate_value,
        output pc_val
    );
endinterface

`default_nettype wire

// File: rtl/program_counter.sv
// ============================================================================
// Module      : program_counter
// Description : 32-bit RV32I fetch PC: increment, absolute load, relative
//               branch or hold. Optional macro PC_ALIGN_EN forces bits [1:0]
//               of every written value (and the reset value) to zero.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module program_counter #(
    parameter logic [31:0] RESET_VAL = 32'h0000_0000,
    parameter int unsigned STEP      = 4
) (
    input  wire logic           clk,
    input  wire logic           clr,
    program_counter_if.slave    bus
);

    localparam logic [31:0] STEP_W = 32'(STEP);

`ifdef PC_ALIGN_EN
    localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;
`else
    localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFF;
`endif

    localparam logic [31:0] RESET_EFF = RESET_VAL & ALIGN_MASK;

    logic [31:0] pc_q;
    logic [31:0] next_raw;
    logic [31:0] next_pc;

    // Branch target is pc + offset + STEP; load beats increment, Disable only stalls increment.
    always_comb begin
        next_raw = pc_q;
        if (bus.load) begin
            if (bus.ALU_out) begin
                next_raw = pc_q + bus.immediate_value + STEP_W;
            end else begin
                next_raw = bus.data;
            end
        end else if (bus.inc && !bus.Disable) begin
            next_raw = pc_q + STEP_W;
        end
        next_pc = next_raw & ALIGN_MASK;
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            pc_q <= RESET_EFF;
        end else begin
            pc_q <= next_pc;
        end
    end

    assign bus.pc_val = pc_q;

endmodule

`default_nettype wire

// File: tb/tb_program_counter.sv
// ============================================================================
// Module      : tb_program_counter
// Description : Randomized + directed scoreboard bench for program_counter.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_program_counter;

    logic clk;
    logic clr;
    int   checks;
    int   errors;

    logic [31:0] exp_q[$];
    logic [31:0] model_pc;

    program_counter_if bus();

    program_counter #(
        .RESET_VAL(32'h0000_0000),
        .STEP     (4)
    ) dut (
        .clk(clk),
        .clr(clr),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] align(input logic [31:0] v);
`ifdef PC_ALIGN_EN
        return v - (v % 4);
`else
        return v;
`endif
    endfunction

    // Reference rules computed with wide signed arithmetic, then reduced modulo 2^32.
    function automatic logic [31:0] model_next(input logic [31:0] pc, input bit ld, input bit alu,
                                               input bit in, input bit dis,
                                               input logic [31:0] d, input logic [31:0] imm);
        longint v;
        logic [63:0] w;
        if (ld && alu)      v = longint'(pc) + longint'($signed(imm)) + 64'sd4;
        else if (ld)        v = longint'(d);
        else if (in && !dis) v = longint'(pc) + 64'sd4;
        else                v = longint'(pc);
        w = 64'(v);
        return align(w[31:0]);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: the PC is a visible result every cycle; compare after each edge that has an entry.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) check("pc_val", bus.pc_val, exp_q.pop_front());
        end
    end

    task automatic step(input bit ld, input bit alu, input bit in, input bit dis,
                        input logic [31:0] d, input logic [31:0] imm);
        @(negedge clk);
        bus.load            = ld;
        bus.ALU_out         = alu;
        bus.inc             = in;
        bus.Disable         = dis;
        bus.data            = d;
        bus.immediate_value = imm;
        model_pc = model_next(model_pc, ld, alu, in, dis, d, imm);
        exp_q.push_back(model_pc);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, $urandom, $urandom);
    endtask

    // Raise clr between edges with a load pending; PC must clear without a clock edge.
    task automatic async_clear();
        @(negedge clk);
        bus.load    = 1'b1;
        bus.ALU_out = 1'b0;
        bus.inc     = 1'b1;
        bus.data    = 32'h0000_1234;
        #2 clr = 1'b1;
        #1 check("async_clr", bus.pc_val, align(32'h0));
        model_pc = align(32'h0);
        exp_q.push_back(model_pc);
        @(negedge clk);
        clr         = 1'b0;
        bus.load    = 1'b0;
        bus.inc     = 1'b0;
        exp_q.push_back(model_pc);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        clr = 1'b1;
        bus.load = 1'b0; bus.inc = 1'b0; bus.ALU_out = 1'b0; bus.Disable = 1'b0;
        bus.data = 32'h0; bus.immediate_value = 32'h0;
        model_pc = align(32'h0);
        repeat (3) @(posedge clk);
        #1 check("reset_hold", bus.pc_val, align(32'h0));
        @(negedge clk);
        clr = 1'b0;

        repeat (3) idle();
        step(0, 0, 1, 0, 32'h0, 32'h0);
        step(0, 0, 1, 0, 32'h0, 32'h0);
        idle();
        async_clear();

        step(1, 0, 0, 0, 32'd20, 32'h0);
        repeat (5) step(0, 0, 1, 1, 32'h0, 32'h0);
        step(1, 0, 1, 0, 32'd40, 32'h0);
        step(1, 0, 0, 0, 32'd20, 32'h0);
        step(0, 0, 0, 0, 32'd77, 32'h0);
        step(1, 1, 0, 1, 32'h0, 32'd8);
        step(1, 0, 0, 0, 32'd100, 32'h0);
        step(1, 1, 0, 0, 32'h0, 32'hFFFF_FFF8);
        step(1, 0, 0, 0, 32'hFFFF_FFFC, 32'h0);
        step(0, 0, 1, 0, 32'h0, 32'h0);
        step(1, 0, 0, 0, 32'd22, 32'h0);
        step(0, 0, 1, 0, 32'h0, 32'h0);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                async_clear();
            end else begin
                step(bit'($urandom_range(0, 3) == 0), bit'($urandom_range(0, 1)),
                     bit'($urandom_range(0, 1)), bit'($urandom_range(0, 3) == 0),
                     ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 + $urandom_range(0, 15) : $urandom,
                     ($urandom_range(0, 1) == 1) ? 32'($signed($urandom_range(0, 64)) - 32) : $urandom);
            end
        end

        @(negedge clk);
        bus.load = 1'b0; bus.inc = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
